// File: rtl/lf_trigger_pkg.sv
// Shared definitions for the low-frequency trigger generator: trigger word
// layout, run-state encoding and the dropped-counter width.
package lf_trigger_pkg;

   localparam int MULTI_BIT    = 31;
   localparam int BEAM_LSB     = 24;
   localparam int BEAM_BITS    = 7;
   localparam int TS_LSB       = 0;
   localparam int TS_FIELD     = 24;
   localparam int DROPPED_BITS = 16;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUNNING  = 2'd1,
      ST_STOPPING = 2'd2
   } run_state_e;

endpackage

// File: rtl/lf_trig_fifo.sv
// Synchronous FIFO with a first-word-fall-through output register and flush.
// Capacity counts the output register, so DEPTH words fit in total.
module lf_trig_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             rd_valid_o,
   input  logic             rd_ready_i
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    mem_cnt_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] out_data_q;
   logic [CW:0]      total;
   logic             pop, load, wr;

   assign pop     = out_valid_q & rd_ready_i;
   assign load    = (mem_cnt_q != '0) && (!out_valid_q || pop);
   assign total   = {1'b0, mem_cnt_q} + (CW + 1)'(out_valid_q);
   // A pop in the same cycle frees a slot, so a write at full capacity still lands.
   assign full_o  = (total == (CW + 1)'(DEPTH)) && !pop;
   assign empty_o = (total == '0);
   assign wr      = wr_en_i && !full_o;

   assign rd_data_o  = out_data_q;
   assign rd_valid_o = out_valid_q;

   always_ff @(posedge clk_i) begin
      if (wr && !flush_i) mem_q[wr_ptr_q] <= wr_data_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         mem_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         mem_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         if (wr) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (load) begin
            rd_ptr_q    <= rd_ptr_q + AW'(1);
            out_data_q  <= mem_q[rd_ptr_q];
            out_valid_q <= 1'b1;
         end else if (pop) begin
            out_valid_q <= 1'b0;
         end
         mem_cnt_q <= mem_cnt_q + CW'(wr) - CW'(load);
      end
   end

endmodule

// File: rtl/lf_trigger_generator.sv
// Beam trigger qualification, holdoff, timestamping and FIFO-buffered trigger
// word output. Define LF_TRIG_COUNT_EN to build the accepted-trigger counter.
module lf_trigger_generator
   import lf_trigger_pkg::*;
#(
   parameter int NBEAMS       = 2,
   parameter int FIFO_DEPTH   = 16,
   parameter int HOLDOFF_BITS = 16,
   parameter int TS_BITS      = 24
) (
   input  logic                    ifclk,
   input  logic                    ifclk_rstn_i,
   input  logic [NBEAMS-1:0]       trig_i,
   input  logic [NBEAMS-1:0]       mask_i,
   input  logic [HOLDOFF_BITS-1:0] holdoff_i,
   input  logic                    runrst_i,
   input  logic                    runstop_i,
   output logic                    running_o,
   output logic [31:0]             m_trig_tdata,
   output logic                    m_trig_tvalid,
   input  logic                    m_trig_tready,
   output logic [DROPPED_BITS-1:0] dropped_o,
   output logic [31:0]             trig_count_o,
   output logic [1:0]              state_o
);

   run_state_e              state_q, state_d;
   logic [TS_BITS-1:0]      ts_q, ts_smp_q;
   logic [NBEAMS-1:0]       q_q;
   logic [HOLDOFF_BITS-1:0] hold_q;
   logic [DROPPED_BITS-1:0] dropped_q;
   logic [BEAM_BITS-1:0]    beam_idx;
   logic                    multi, qualify, accept, drop;
   logic                    fifo_full, fifo_empty;
   logic [31:0]             word;

   assign running_o = (state_q == ST_RUNNING);
   assign dropped_o = dropped_q;
   assign state_o   = state_q;

   always_comb begin
      beam_idx = '0;
      for (int i = NBEAMS - 1; i >= 0; i--) begin
         if (q_q[i]) beam_idx = BEAM_BITS'(i);
      end
      // More than one bit set exactly when clearing the lowest bit leaves something.
      multi = (q_q & (q_q - NBEAMS'(1))) != '0;
      word  = '0;
      word[MULTI_BIT]               = multi;
      word[BEAM_LSB +: BEAM_BITS]   = beam_idx;
      word[TS_LSB +: TS_FIELD]      = TS_FIELD'(ts_smp_q);
      qualify = (state_q == ST_RUNNING) && (q_q != '0) && (hold_q == '0) && !runrst_i;
      accept  = qualify && !fifo_full;
      drop    = qualify && fifo_full;
   end

   always_comb begin
      state_d = state_q;
      if (runrst_i) begin
         state_d = ST_RUNNING;
      end else begin
         unique case (state_q)
            ST_IDLE:     state_d = ST_IDLE;
            ST_RUNNING:  if (runstop_i) state_d = ST_STOPPING;
            ST_STOPPING: if (fifo_empty) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge ifclk or negedge ifclk_rstn_i) begin
      if (!ifclk_rstn_i) begin
         state_q   <= ST_IDLE;
         ts_q      <= '0;
         ts_smp_q  <= '0;
         q_q       <= '0;
         hold_q    <= '0;
         dropped_q <= '0;
      end else begin
         state_q <= state_d;
         if (runrst_i) begin
            ts_q      <= '0;
            ts_smp_q  <= '0;
            q_q       <= '0;
            hold_q    <= '0;
            dropped_q <= '0;
         end else begin
            q_q      <= trig_i & ~mask_i;
            ts_smp_q <= ts_q;
            if (state_q == ST_RUNNING) ts_q <= ts_q + TS_BITS'(1);
            if (accept) hold_q <= holdoff_i;
            else if (hold_q != '0) hold_q <= hold_q - HOLDOFF_BITS'(1);
            if (drop && (dropped_q != '1)) dropped_q <= dropped_q + DROPPED_BITS'(1);
         end
      end
   end

`ifdef LF_TRIG_COUNT_EN
   logic [31:0] count_q;

   always_ff @(posedge ifclk or negedge ifclk_rstn_i) begin
      if (!ifclk_rstn_i) count_q <= '0;
      else if (runrst_i) count_q <= '0;
      else if (accept)   count_q <= count_q + 32'd1;
   end

   assign trig_count_o = count_q;
`else
   assign trig_count_o = '0;
`endif

   // Output stream: a word transfers on any edge where m_trig_tvalid and
   // m_trig_tready are both high; tdata holds while tvalid is high and tready low.
   lf_trig_fifo #(
      .WIDTH (32),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i      (ifclk),
      .rst_ni     (ifclk_rstn_i),
      .flush_i    (runrst_i),
      .wr_en_i    (accept),
      .wr_data_i  (word),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .rd_data_o  (m_trig_tdata),
      .rd_valid_o (m_trig_tvalid),
      .rd_ready_i (m_trig_tready)
   );

endmodule

// File: tb/tb_lf_trigger_generator.sv
// Scoreboard bench for lf_trigger_generator: a queue-based reference model
// predicts accepted words, occupancy, drops and run state from the input rules.
module tb_lf_trigger_generator;
   import lf_trigger_pkg::*;

   localparam int NB    = 2;
   localparam int DEPTH = 16;
   localparam int HB    = 16;
   localparam int TSB   = 24;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NB-1:0] trig, mask;
   logic [HB-1:0] holdoff;
   logic          runrst, runstop, tready;
   logic          running, tvalid;
   logic [31:0]   tdata, trig_count;
   logic [15:0]   dropped;
   logic [1:0]    dbg_state;

   always #5 clk = ~clk;

   lf_trigger_generator #(
      .NBEAMS(NB), .FIFO_DEPTH(DEPTH), .HOLDOFF_BITS(HB), .TS_BITS(TSB)
   ) dut (
      .ifclk         (clk),
      .ifclk_rstn_i  (rst_n),
      .trig_i        (trig),
      .mask_i        (mask),
      .holdoff_i     (holdoff),
      .runrst_i      (runrst),
      .runstop_i     (runstop),
      .running_o     (running),
      .m_trig_tdata  (tdata),
      .m_trig_tvalid (tvalid),
      .m_trig_tready (tready),
      .dropped_o     (dropped),
      .trig_count_o  (trig_count),
      .state_o       (dbg_state)
   );

   int cmp_cnt = 0;
   int err_cnt = 0;
   int xfer_cnt = 0;

   logic [31:0] exp_q[$];
   typedef struct { logic [31:0] word; int avail; } ent_t;
   ent_t mq[$];

   // Reference model: 0 idle, 1 running, 2 stopping.
   int          m_state, m_hold, m_drop, m_pts, edge_n;
   int unsigned m_ts, m_cnt;
   logic [NB-1:0] m_pq;
   bit          m_vis;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] make_word(input logic [NB-1:0] q, input int ts);
      logic [6:0] idx = 7'd0;
      for (int i = 0; i < NB; i++) begin
         if (q[i]) begin
            idx = 7'(i);
            break;
         end
      end
      return {($countones(q) > 1) ? 1'b1 : 1'b0, idx, 24'(ts)};
   endfunction

   function automatic logic [1:0] exp_state();
      case (m_state)
         1:       return ST_RUNNING;
         2:       return ST_STOPPING;
         default: return ST_IDLE;
      endcase
   endfunction

   task automatic model_reset();
      m_state = 0; m_ts = 0; m_hold = 0; m_drop = 0; m_cnt = 0;
      m_pq = '0; m_pts = 0; m_vis = 0;
      mq.delete(); exp_q.delete();
   endtask

   task automatic model_edge();
      int  size0 = mq.size();
      bit  pop   = m_vis && tready;
      logic [31:0] w;
      edge_n++;
      if (runrst) begin
         model_reset();
         m_state = 1;
      end else begin
         if (pop) void'(mq.pop_front());
         if (m_state == 1 && m_pq != '0 && m_hold == 0) begin
            if (mq.size() == DEPTH) begin
               if (m_drop < 65535) m_drop++;
            end else begin
               w = make_word(m_pq, m_pts);
               mq.push_back('{word: w, avail: edge_n + 1});
               exp_q.push_back(w);
               m_hold = int'(holdoff);
               m_cnt++;
            end
         end else if (m_hold > 0) begin
            m_hold--;
         end
         m_pq  = trig & ~mask;
         m_pts = int'(m_ts);
         if (m_state == 1) m_ts = (m_ts + 1) % (1 << TSB);
         if (m_state == 1 && runstop) m_state = 2;
         else if (m_state == 2 && size0 == 0) m_state = 0;
      end
      m_vis = (mq.size() > 0) && (mq[0].avail <= edge_n);
   endtask

   task automatic cyc(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         model_edge();
         #1;
      end
   endtask

   task automatic pulse_trig(input logic [NB-1:0] t, input int gap);
      trig = t;
      cyc();
      trig = '0;
      cyc(gap);
   endtask

   task automatic pulse_runrst();
      runrst = 1'b1;
      cyc();
      runrst = 1'b0;
   endtask

   // Monitor: per-cycle status against the model, data popped on each transfer.
   always @(negedge clk) begin
      if (rst_n) begin
         check("tvalid", 32'(tvalid), 32'(m_vis));
         check("running", 32'(running), 32'(m_state == 1));
         check("dropped", 32'(dropped), 32'(m_drop));
         check("state", 32'(dbg_state), 32'(exp_state()));
`ifdef LF_TRIG_COUNT_EN
         check("trig_count", trig_count, m_cnt);
`else
         check("trig_count", trig_count, 32'd0);
`endif
         if (tvalid && tready) begin
            xfer_cnt++;
            if (exp_q.size() == 0) check("unexpected_word", tdata, 32'hxxxx_xxxx);
            else check("tdata", tdata, exp_q.pop_front());
         end
      end
   end

   task automatic fire_and_check(input logic [NB-1:0] t, input logic [NB-1:0] m,
                                 input logic [7:0] exp_hi, input string name);
      mask = m;
      trig = t;
      cyc();
      trig = '0;
      cyc(2);
      check(name, 32'(tdata[31:24]), 32'(exp_hi));
      cyc(2);
   endtask

   int x0;

   initial begin
      rst_n = 1'b0; trig = '0; mask = '0; holdoff = '0;
      runrst = 1'b0; runstop = 1'b0; tready = 1'b1; edge_n = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_tvalid", 32'(tvalid), 32'd0);
      check("rst_tdata", tdata, 32'd0);
      check("rst_running", 32'(running), 32'd0);
      check("rst_dropped", 32'(dropped), 32'd0);
      check("rst_count", trig_count, 32'd0);
      check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      rst_n = 1'b1;
      cyc(2);

      // First word: trigger seen at timestamp 5, visible two edges later.
      pulse_runrst();
      cyc(5);
      trig = 2'b10;
      cyc();
      trig = '0;
      cyc();
      check("first_tvalid_early", 32'(tvalid), 32'd0);
      cyc();
      check("first_tvalid", 32'(tvalid), 32'd1);
      check("first_tdata", tdata, 32'h0100_0005);
      cyc(2);

      fire_and_check(2'b11, 2'b00, 8'h80, "multi_beam0");
      fire_and_check(2'b11, 2'b01, 8'h01, "masked_beam1");
      mask = '0;

      // Holdoff of 3 with a trigger held for 10 cycles.
      holdoff = 16'd3;
      x0 = xfer_cnt;
      trig = 2'b01;
      cyc(10);
      trig = '0;
      cyc(8);
      check("holdoff_words", xfer_cnt - x0, 32'd3);
      holdoff = '0;

      // Fill with the stream stalled, then drain.
      tready = 1'b0;
      x0 = xfer_cnt;
      for (int i = 0; i < 20; i++) pulse_trig(2'b01, 1);
      cyc(3);
      check("full_dropped", 32'(dropped), 32'd4);
      check("full_tvalid", 32'(tvalid), 32'd1);
      tready = 1'b1;
      cyc(25);
      check("full_drained", xfer_cnt - x0, 32'd16);

      // Stop with three words pending.
      tready = 1'b0;
      x0 = xfer_cnt;
      for (int i = 0; i < 3; i++) pulse_trig(2'b10, 1);
      cyc(3);
      runstop = 1'b1;
      cyc();
      runstop = 1'b0;
      check("stop_running", 32'(running), 32'd0);
      cyc(2);
      tready = 1'b1;
      cyc(10);
      check("stop_state_idle", 32'(dbg_state), 32'(ST_IDLE));
      check("stop_drained", xfer_cnt - x0, 32'd3);
      x0 = xfer_cnt;
      for (int i = 0; i < 5; i++) pulse_trig(2'b11, 1);
      cyc(3);
      check("idle_ignored", xfer_cnt - x0, 32'd0);
      runrst = 1'b1; runstop = 1'b1;
      cyc();
      runrst = 1'b0; runstop = 1'b0;
      check("rr_rs_running", 32'(running), 32'd1);
      check("rr_rs_dropped", 32'(dropped), 32'd0);

      // Randomized run with stalls, restarts and stops.
      for (int i = 0; i < 2500; i++) begin
         trig    = ($urandom_range(0, 2) == 0) ? NB'($urandom) : '0;
         tready  = ((i % 500) < 40) ? 1'b0 : ($urandom_range(0, 9) < 7);
         runstop = ($urandom_range(0, 199) == 0);
         runrst  = ($urandom_range(0, 299) == 0) || (m_state == 0 && $urandom_range(0, 19) == 0);
         if (i % 50 == 0) holdoff = HB'($urandom_range(0, 4));
         if (i % 300 == 0) mask = ($urandom_range(0, 2) == 0) ? NB'($urandom) : '0;
         cyc();
      end
      trig = '0; runrst = 1'b0; runstop = 1'b0; tready = 1'b1;
      cyc(40);
      check("random_leftover", exp_q.size(), 32'd0);

      // Asynchronous reset while a word is stalled on the output.
      mask = '0; holdoff = '0; tready = 1'b0;
      pulse_runrst();
      for (int i = 0; i < 18; i++) pulse_trig(2'b01, 1);
      cyc(2);
      check("pre_rst_tvalid", 32'(tvalid), 32'd1);
      check("pre_rst_dropped", 32'(dropped), 32'd2);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("async_tvalid", 32'(tvalid), 32'd0);
      check("async_tdata", tdata, 32'd0);
      check("async_dropped", 32'(dropped), 32'd0);
      check("async_count", trig_count, 32'd0);
      check("async_running", 32'(running), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
